// File: rtl/std_div_arbiter_if.sv
// std_div_arbiter_if: requester-side go/done divide ports plus arbiter status.
interface std_div_arbiter_if #(parameter int width = 32, parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req_go;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ*width-1:0] req_left;
  logic [NUM_REQ*width-1:0] req_right;
  logic [NUM_REQ*width-1:0] out_quotient;
  logic [NUM_REQ*width-1:0] out_remainder;
  logic busy;
  modport master(output req_go, req_left, req_right,
                 input req_done, out_quotient, out_remainder, grant, busy);
  modport slave(input req_go, req_left, req_right,
                output req_done, out_quotient, out_remainder, grant, busy);
endinterface

// File: rtl/std_div_arbiter.sv
// std_div_arbiter: shares one iterative std_div between NUM_REQ go/done requesters.
// Round-robin by default; define DIV_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module std_div #(parameter int width = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             done
);
  localparam int CW = $clog2(width + 1);
  logic running;
  logic [CW-1:0] cnt;
  logic [width-1:0] rem, quo, dvs;
  logic [width:0] ext, diff;
  logic fit;
  always_comb begin
    ext = {rem, quo[width-1]};
    diff = ext - {1'b0, dvs};
    fit = ext >= {1'b0, dvs};
  end
  // Dropping go while running aborts, so two idle-go cycles always leave the divider ready.
  always_ff @(posedge clk)
    if (reset) begin
      running <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (running) begin
      if (!go) running <= 1'b0;
      else begin
        rem <= fit ? diff[width-1:0] : ext[width-1:0];
        quo <= {quo[width-2:0], fit};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(width - 1)) begin
          running <= 1'b0;
          done <= 1'b1;
        end
      end
    end else if (go && !done) begin
      done <= left == '0;
      running <= left != '0;
      cnt <= '0;
      rem <= '0;
      quo <= left;
      dvs <= right;
    end else done <= 1'b0;
  assign out_quotient = quo;
  assign out_remainder = rem;
endmodule

module std_div_arbiter #(parameter int width = 32, parameter int NUM_REQ = 4) (
  input logic clk,
  input logic reset,
  std_div_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;
  state_t state;
  logic [IW-1:0] rr, own, pick;
  logic [NUM_REQ-1:0] armed, elig, grant, req_done;
  logic [NUM_REQ*width-1:0] out_q, out_r;
  logic [width-1:0] op_l, op_r, div_q, div_r;
  logic found, div_go, div_done;
  int idx;
  assign elig = bus.req_go & armed;
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = 0;
`ifdef DIV_ARB_FIXED_PRIORITY_EN
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[k]) begin
        found = 1'b1;
        pick = IW'(k);
      end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick = IW'(idx);
      end
    end
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      req_done <= '0;
      out_q <= '0;
      out_r <= '0;
      rr <= IW'(NUM_REQ - 1);
      armed <= '1;
      div_go <= 1'b0;
      own <= '0;
      op_l <= '0;
      op_r <= '0;
    end else begin
      // A done pulse disarms its requester until go is seen low again.
      armed <= (armed & ~req_done) | ~bus.req_go;
      case (state)
        IDLE: if (found) begin
          own <= pick;
          rr <= pick;
          op_l <= bus.req_left[pick*width +: width];
          op_r <= bus.req_right[pick*width +: width];
          grant <= NUM_REQ'(1) << pick;
          state <= RUN;
        end
        RUN: if (div_done) begin
          div_go <= 1'b0;
          state <= DONE;
          if (bus.req_go[own]) begin
            out_q[own*width +: width] <= div_q;
            out_r[own*width +: width] <= div_r;
            req_done[own] <= 1'b1;
          end
        end else div_go <= 1'b1;
        DONE: begin
          req_done <= '0;
          grant <= '0;
          state <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  std_div #(.width(width)) u_div (
    .clk(clk),
    .reset(reset),
    .go(div_go),
    .left(op_l),
    .right(op_r),
    .out_quotient(div_q),
    .out_remainder(div_r),
    .done(div_done)
  );
  assign bus.grant = grant;
  assign bus.req_done = req_done;
  assign bus.out_quotient = out_q;
  assign bus.out_remainder = out_r;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_std_div_arbiter.sv
// tb_std_div_arbiter: scoreboard bench for std_div_arbiter with width=8, NUM_REQ=4.
module tb_std_div_arbiter;
  localparam int W = 8, N = 4;
  typedef struct packed {
    logic [1:0] idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  exp_t sb[$];
  exp_t e;
  int done_cnt[N];
  int grant_log[$];
  logic [N-1:0] prev_grant = '0;

  std_div_arbiter_if #(.width(W), .NUM_REQ(N)) bus();
  std_div_arbiter #(.width(W), .NUM_REQ(N)) dut(.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Every done pulse pops the oldest expected result and compares the owner's slices.
  always @(negedge clk) begin
    if (bus.grant != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (bus.grant[i]) grant_log.push_back(i);
    prev_grant = bus.grant;
    for (int i = 0; i < N; i++)
      if (bus.req_done[i] === 1'b1) begin
        done_cnt[i]++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected req=%0d got=done want=none", i);
        end else begin
          e = sb.pop_front();
          if ({2'(i), bus.out_quotient[i*W +: W], bus.out_remainder[i*W +: W]} !== e) begin
            errors++;
            $display("FAIL result req=%0d got=%0d q=%0d r=%0d want=%0d q=%0d r=%0d", i, i,
                     bus.out_quotient[i*W +: W], bus.out_remainder[i*W +: W], e.idx, e.q, e.r);
          end
        end
      end
  end

  task automatic set_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
    bus.req_left[i*W +: W] = l;
    bus.req_right[i*W +: W] = r;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    bus.req_go = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_done[i] !== 1'b1 && n < 300);
    if (bus.req_done[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_done req=%0d got=0 want=1", i);
    end
  endtask

  task automatic wait_grant(input logic [N-1:0] g, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant !== g && n < 300);
    checks++;
    if (bus.grant !== g) begin
      errors++;
      $display("FAIL grant_wait got=%b want=%b", bus.grant, g);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_go = '0;
    bus.req_left = '0;
    bus.req_right = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant got=%b want=0", bus.grant); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++;
    if (bus.req_done !== '0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.req_done); end
    checks++;
    if (bus.out_quotient !== '0) begin errors++; $display("FAIL reset_quot got=%h want=0", bus.out_quotient); end
    checks++;
    if (bus.out_remainder !== '0) begin errors++; $display("FAIL reset_rem got=%h want=0", bus.out_remainder); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int n;
    reset_dut();
    set_op(0, 100, 7);
    sb.push_back(exp_t'{2'd0, 8'd14, 8'd2});
    bus.req_go[0] = 1'b1;
    wait_grant(4'b0001, n);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", bus.busy); end
    wait_done(0);
    bus.req_go[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_done[0] !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b want=0", bus.req_done[0]); end
    checks++;
    if (bus.out_quotient[7:0] !== 8'd14) begin errors++; $display("FAIL single_held got=%0d want=14", bus.out_quotient[7:0]); end
  endtask

  task automatic test_back_to_back();
    int n;
    int base[3];
    reset_dut();
    for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
    set_op(0, 50, 5);
    set_op(1, 9, 4);
    set_op(2, 255, 16);
    sb.push_back(exp_t'{2'd0, 8'd10, 8'd0});
    sb.push_back(exp_t'{2'd1, 8'd2, 8'd1});
    sb.push_back(exp_t'{2'd2, 8'd15, 8'd15});
    bus.req_go[2:0] = 3'b111;
    wait_grant(4'b0001, n);
    wait_done(0);
    bus.req_go[0] = 1'b0;
    wait_grant(4'b0010, n);
    checks++;
    if (n < 2) begin errors++; $display("FAIL b2b_gap1 got=%0d want>=2", n); end
    wait_done(1);
    bus.req_go[1] = 1'b0;
    wait_grant(4'b0100, n);
    checks++;
    if (n < 2) begin errors++; $display("FAIL b2b_gap2 got=%0d want>=2", n); end
    wait_done(2);
    bus.req_go[2] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_cnt[i] - base[i] !== 1) begin
        errors++;
        $display("FAIL b2b_count req=%0d got=%0d want=1", i, done_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_held_go();
    int k;
    bit ok = 1'b1;
    reset_dut();
    k = done_cnt[1];
    set_op(1, 20, 3);
    sb.push_back(exp_t'{2'd1, 8'd6, 8'd2});
    bus.req_go[1] = 1'b1;
    wait_done(1);
    repeat (8) begin
      @(negedge clk);
      if (bus.grant !== '0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL held_regrant got=regrant want=none"); end
    checks++;
    if (done_cnt[1] - k !== 1) begin errors++; $display("FAIL held_count got=%0d want=1", done_cnt[1] - k); end
    bus.req_go[1] = 1'b0;
    @(negedge clk);
    sb.push_back(exp_t'{2'd1, 8'd6, 8'd2});
    bus.req_go[1] = 1'b1;
    wait_done(1);
    bus.req_go[1] = 1'b0;
  endtask

  task automatic test_withdraw();
    int n, k;
    reset_dut();
    set_op(3, 30, 4);
    sb.push_back(exp_t'{2'd3, 8'd7, 8'd2});
    bus.req_go[3] = 1'b1;
    wait_done(3);
    bus.req_go[3] = 1'b0;
    repeat (4) @(negedge clk);
    set_op(3, 60, 7);
    bus.req_go[3] = 1'b1;
    wait_grant(4'b1000, n);
    repeat (3) @(negedge clk);
    k = done_cnt[3];
    bus.req_go[3] = 1'b0;
    set_op(0, 10, 3);
    sb.push_back(exp_t'{2'd0, 8'd3, 8'd1});
    bus.req_go[0] = 1'b1;
    wait_grant(4'b0001, n);
    wait_done(0);
    bus.req_go[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt[3] !== k) begin errors++; $display("FAIL withdraw_done got=%0d want=%0d", done_cnt[3], k); end
    checks++;
    if ({bus.out_quotient[31:24], bus.out_remainder[31:24]} !== {8'd7, 8'd2}) begin
      errors++;
      $display("FAIL withdraw_slice got=%0d/%0d want=7/2", bus.out_quotient[31:24], bus.out_remainder[31:24]);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    reset_dut();
    set_op(2, 50, 6);
    sb.push_back(exp_t'{2'd2, 8'd8, 8'd2});
    bus.req_go[2] = 1'b1;
    wait_done(2);
    bus.req_go[2] = 1'b0;
    repeat (3) @(negedge clk);
    set_op(2, 100, 7);
    bus.req_go[2] = 1'b1;
    wait_grant(4'b0100, n);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.req_go[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.grant, bus.busy, bus.req_done} !== '0) begin
      errors++;
      $display("FAIL midreset_ctl got=%b/%b/%b want=0/0/0", bus.grant, bus.busy, bus.req_done);
    end
    checks++;
    if ({bus.out_quotient, bus.out_remainder} !== '0) begin
      errors++;
      $display("FAIL midreset_out got=%h/%h want=0/0", bus.out_quotient, bus.out_remainder);
    end
    set_op(2, 81, 9);
    sb.push_back(exp_t'{2'd2, 8'd9, 8'd0});
    bus.req_go[2] = 1'b1;
    wait_done(2);
    bus.req_go[2] = 1'b0;
  endtask

  task automatic test_fairness();
    int n, g0, who;
    int order[4];
`ifdef DIV_ARB_FIXED_PRIORITY_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 3, 0, 3};
`endif
    reset_dut();
    set_op(0, 77, 5);
    set_op(3, 200, 9);
    for (int s = 0; s < 4; s++)
      sb.push_back(order[s] == 0 ? exp_t'{2'd0, 8'd15, 8'd2} : exp_t'{2'd3, 8'd22, 8'd2});
    g0 = grant_log.size();
    bus.req_go = 4'b1001;
    for (int s = 0; s < 4; s++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.req_done === '0 && n < 300);
      if (bus.req_done === '0) begin
        checks++;
        errors++;
        $display("FAIL fair_timeout step=%0d got=0 want=done", s);
        break;
      end
      who = bus.req_done[3] ? 3 : 0;
      bus.req_go[who] = 1'b0;
      if (s < 3) begin
        @(negedge clk);
        bus.req_go[who] = 1'b1;
      end
    end
    bus.req_go = '0;
    repeat (40) @(negedge clk);
    checks++;
    if (grant_log.size() - g0 < 4) begin
      errors++;
      $display("FAIL fair_grants got=%0d want>=4", grant_log.size() - g0);
    end else
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (grant_log[g0+s] !== order[s]) begin
          errors++;
          $display("FAIL fair_order step=%0d got=%0d want=%0d", s, grant_log[g0+s], order[s]);
        end
      end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_held_go();
    test_withdraw();
    test_mid_reset();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
